// File: rtl/axi_ddr_burst_master.sv
// Drains an FWFT FIFO into DDR as fixed-length INCR bursts over a wrapping address
// window, optionally reading each burst back and comparing it against a local copy.
module axi_ddr_burst_master #(
  parameter int                DATA_W     = 256,
  parameter int                ADDR_W     = 32,
  parameter int                ID_W       = 8,
  parameter logic [ID_W-1:0]   AXI_ID     = '0,
  parameter int                BURST_LEN  = 4,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] STOP_ADDR  = 'h0010_0000
) (
  input  logic                axi_clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [15:0]         i_num_bursts,
  input  logic                i_verify,
  input  logic                i_pause,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                check_empty,
  output logic                read_enable,
  output logic [ID_W-1:0]     DDR_AID_0,
  output logic [ADDR_W-1:0]   DDR_AADDR_0,
  output logic [7:0]          DDR_ALEN_0,
  output logic [2:0]          DDR_ASIZE_0,
  output logic [1:0]          DDR_ABURST_0,
  output logic [1:0]          DDR_ALOCK_0,
  output logic                DDR_AVALID_0,
  output logic                DDR_ATYPE_0,
  input  logic                DDR_AREADY_0,
  output logic [ID_W-1:0]     DDR_WID_0,
  output logic [DATA_W-1:0]   DDR_WDATA_0,
  output logic [DATA_W/8-1:0] DDR_WSTRB_0,
  output logic                DDR_WLAST_0,
  output logic                DDR_WVALID_0,
  input  logic                DDR_WREADY_0,
  input  logic [ID_W-1:0]     DDR_BID_0,
  input  logic                DDR_BVALID_0,
  output logic                DDR_BREADY_0,
  input  logic [ID_W-1:0]     DDR_RID_0,
  input  logic [DATA_W-1:0]   DDR_RDATA_0,
  input  logic [1:0]          DDR_RRESP_0,
  input  logic                DDR_RLAST_0,
  input  logic                DDR_RVALID_0,
  output logic                DDR_RREADY_0,
  output logic                o_busy,
  output logic                o_done,
  output logic [15:0]         o_bursts_done,
  output logic                o_compare_error,
  output logic [15:0]         o_err_count,
  output logic                o_resp_error
);

  localparam int              BW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0]   LAST_BEAT   = BW'(BURST_LEN - 1);
  localparam logic [ADDR_W:0] BURST_BYTES = (ADDR_W+1)'(BURST_LEN * DATA_W / 8);
  localparam logic [2:0]      SIZE        = 3'($clog2(DATA_W / 8));

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_NEXT, S_HOLD
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [BW-1:0]       beat;
  logic [15:0]         num_q;
  logic                verify_q;
  logic [DATA_W-1:0]   buffer [2**BW];

  logic avalid, atype, wvalid, bready, rready;
  logic wr_hs, rd_hs, last_beat, run_end, start_ok;
  logic [15:0]       bursts_nxt;
  logic [ADDR_W:0]   addr_inc;
  logic [ADDR_W-1:0] addr_nxt;

  assign last_beat  = (beat == LAST_BEAT);
  assign wr_hs      = wvalid & DDR_WREADY_0;
  assign rd_hs      = rready & DDR_RVALID_0;
  assign start_ok   = (state == S_IDLE) && i_start;
  assign bursts_nxt = o_bursts_done + 16'd1;
  assign run_end    = (bursts_nxt == num_q);
  assign addr_inc   = {1'b0, addr} + BURST_BYTES;
  assign addr_nxt   = (addr_inc >= {1'b0, STOP_ADDR}) ? START_ADDR : addr_inc[ADDR_W-1:0];

  always_ff @(posedge axi_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    avalid    = 1'b0;
    atype     = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    rready    = 1'b0;
    case (state)
      S_IDLE:    if (i_start && i_num_bursts != 16'd0) state_nxt = S_WR_ADDR;
      S_WR_ADDR: begin
        avalid = 1'b1;
        atype  = 1'b1;
        if (DDR_AREADY_0) state_nxt = S_WR_DATA;
      end
      S_WR_DATA: begin
        // FWFT head stays put until popped, so WVALID only drops before a handshake.
        wvalid = !check_empty;
        if (wvalid && DDR_WREADY_0 && last_beat) state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (DDR_BVALID_0) state_nxt = verify_q ? S_RD_ADDR : S_NEXT;
      end
      S_RD_ADDR: begin
        avalid = 1'b1;
        if (DDR_AREADY_0) state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (DDR_RVALID_0 && last_beat) state_nxt = S_NEXT;
      end
      S_NEXT:    state_nxt = run_end ? S_IDLE : (i_pause ? S_HOLD : S_WR_ADDR);
      S_HOLD:    if (!i_pause) state_nxt = S_WR_ADDR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      addr            <= START_ADDR;
      beat            <= '0;
      num_q           <= '0;
      verify_q        <= 1'b0;
      o_done          <= 1'b0;
      o_bursts_done   <= '0;
      o_compare_error <= 1'b0;
      o_err_count     <= '0;
      o_resp_error    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (start_ok) begin
        addr            <= START_ADDR;
        beat            <= '0;
        num_q           <= i_num_bursts;
        verify_q        <= i_verify;
        o_bursts_done   <= '0;
        o_compare_error <= 1'b0;
        o_err_count     <= '0;
        o_resp_error    <= 1'b0;
        if (i_num_bursts == 16'd0) o_done <= 1'b1;
      end
      if (wr_hs) beat <= last_beat ? '0 : beat + 1'b1;
      if (bready && DDR_BVALID_0 && DDR_BID_0 != AXI_ID) o_resp_error <= 1'b1;
      if (rd_hs) begin
        beat <= last_beat ? '0 : beat + 1'b1;
        if (DDR_RDATA_0 != buffer[beat]) begin
          o_compare_error <= 1'b1;
          if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
        end
        // Beat count, not RLAST, closes the burst; a misplaced RLAST is only flagged.
        if (DDR_RRESP_0 != 2'b00 || DDR_RID_0 != AXI_ID || DDR_RLAST_0 != last_beat)
          o_resp_error <= 1'b1;
      end
      if (state == S_NEXT) begin
        o_bursts_done <= bursts_nxt;
        addr          <= addr_nxt;
        if (run_end) o_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (wr_hs && verify_q) buffer[beat] <= data_in;
  end

  assign read_enable  = wr_hs;
  assign o_busy       = (state != S_IDLE);
  assign DDR_AID_0    = AXI_ID;
  assign DDR_AADDR_0  = addr;
  assign DDR_AVALID_0 = avalid;
  assign DDR_ATYPE_0  = atype;
  assign DDR_ALEN_0   = avalid ? 8'(BURST_LEN - 1) : 8'd0;
  assign DDR_ASIZE_0  = avalid ? SIZE : 3'd0;
  assign DDR_ABURST_0 = avalid ? 2'b01 : 2'b00;
  assign DDR_ALOCK_0  = 2'b00;
  assign DDR_WID_0    = AXI_ID;
  assign DDR_WDATA_0  = (state == S_WR_DATA) ? data_in : '0;
  assign DDR_WSTRB_0  = '1;
  assign DDR_WLAST_0  = (state == S_WR_DATA) && last_beat;
  assign DDR_WVALID_0 = wvalid;
  assign DDR_BREADY_0 = bready;
  assign DDR_RREADY_0 = rready;

endmodule

// File: tb/tb_axi_ddr_burst_master.sv
// Directed bench: FWFT FIFO and zero-wait DDR slave models around the burst master.
module tb_axi_ddr_burst_master;
  localparam int DATA_W = 256, ADDR_W = 32, ID_W = 8;

  logic axi_clk = 0, rst = 1;
  logic i_start = 0, i_verify = 0, i_pause = 0;
  logic [15:0] i_num_bursts = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic check_empty = 1, read_enable;
  logic [ID_W-1:0] DDR_AID_0, DDR_WID_0;
  logic [ADDR_W-1:0] DDR_AADDR_0;
  logic [7:0] DDR_ALEN_0;
  logic [2:0] DDR_ASIZE_0;
  logic [1:0] DDR_ABURST_0, DDR_ALOCK_0;
  logic DDR_AVALID_0, DDR_ATYPE_0, DDR_AREADY_0 = 1;
  logic [DATA_W-1:0] DDR_WDATA_0;
  logic [DATA_W/8-1:0] DDR_WSTRB_0;
  logic DDR_WLAST_0, DDR_WVALID_0, DDR_WREADY_0 = 1;
  logic [ID_W-1:0] DDR_BID_0 = '0, DDR_RID_0 = '0;
  logic DDR_BVALID_0 = 0, DDR_BREADY_0;
  logic [DATA_W-1:0] DDR_RDATA_0 = '0;
  logic [1:0] DDR_RRESP_0 = '0;
  logic DDR_RLAST_0 = 0, DDR_RVALID_0 = 0, DDR_RREADY_0;
  logic o_busy, o_done, o_compare_error, o_resp_error;
  logic [15:0] o_bursts_done, o_err_count;

  axi_ddr_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .AXI_ID(8'h00),
    .BURST_LEN(4), .START_ADDR(32'h0), .STOP_ADDR(32'h100)) dut (
    .axi_clk(axi_clk), .rst(rst), .i_start(i_start), .i_num_bursts(i_num_bursts),
    .i_verify(i_verify), .i_pause(i_pause), .data_in(data_in), .check_empty(check_empty),
    .read_enable(read_enable), .DDR_AID_0(DDR_AID_0), .DDR_AADDR_0(DDR_AADDR_0),
    .DDR_ALEN_0(DDR_ALEN_0), .DDR_ASIZE_0(DDR_ASIZE_0), .DDR_ABURST_0(DDR_ABURST_0),
    .DDR_ALOCK_0(DDR_ALOCK_0), .DDR_AVALID_0(DDR_AVALID_0), .DDR_ATYPE_0(DDR_ATYPE_0),
    .DDR_AREADY_0(DDR_AREADY_0), .DDR_WID_0(DDR_WID_0), .DDR_WDATA_0(DDR_WDATA_0),
    .DDR_WSTRB_0(DDR_WSTRB_0), .DDR_WLAST_0(DDR_WLAST_0), .DDR_WVALID_0(DDR_WVALID_0),
    .DDR_WREADY_0(DDR_WREADY_0), .DDR_BID_0(DDR_BID_0), .DDR_BVALID_0(DDR_BVALID_0),
    .DDR_BREADY_0(DDR_BREADY_0), .DDR_RID_0(DDR_RID_0), .DDR_RDATA_0(DDR_RDATA_0),
    .DDR_RRESP_0(DDR_RRESP_0), .DDR_RLAST_0(DDR_RLAST_0), .DDR_RVALID_0(DDR_RVALID_0),
    .DDR_RREADY_0(DDR_RREADY_0), .o_busy(o_busy), .o_done(o_done),
    .o_bursts_done(o_bursts_done), .o_compare_error(o_compare_error),
    .o_err_count(o_err_count), .o_resp_error(o_resp_error));

  always #5 axi_clk = ~axi_clk;

  int checks = 0, errors = 0;
  logic [63:0] fifo_q[$], w_data[$], aw_addr[$];
  logic        w_last[$], aw_type[$];
  logic [63:0] rd_tbl [4];
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [2:0]  r_cnt = '0;
  logic b_pend = 0, r_act = 0, gap_en = 0, gap_done = 0, gap_act = 0;
  int pops = 0, done_cnt = 0, av_cyc = 0, viol = 0, gap_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sees pre-edge values, records handshakes and advances the slave/FIFO models.
  always @(posedge axi_clk) begin
    if (rst) begin
      b_pend = 0; r_act = 0; r_cnt = '0;
    end else begin
      if (DDR_AVALID_0) av_cyc++;
      if (DDR_AVALID_0 && DDR_AREADY_0) begin
        aw_addr.push_back(64'(DDR_AADDR_0));
        aw_type.push_back(DDR_ATYPE_0);
        aw_len = DDR_ALEN_0; aw_size = DDR_ASIZE_0;
        if (!DDR_ATYPE_0) begin r_act = 1; r_cnt = '0; end
      end
      if (DDR_WVALID_0 && DDR_WREADY_0) begin
        w_data.push_back(DDR_WDATA_0[63:0]);
        w_last.push_back(DDR_WLAST_0);
        if (DDR_WLAST_0) b_pend = 1;
      end
      if (read_enable) begin
        pops++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      if (DDR_BVALID_0 && DDR_BREADY_0) b_pend = 0;
      if (DDR_RVALID_0 && DDR_RREADY_0) begin
        r_cnt = r_cnt + 3'd1;
        if (r_cnt == 3'd4) r_act = 0;
      end
      if (o_done) done_cnt++;
      if (gap_act && (DDR_WVALID_0 || read_enable)) viol++;
    end
  end

  always @(negedge axi_clk) begin
    if (gap_en && !gap_done && pops == 2) begin gap_cnt = 5; gap_done = 1; end
    gap_act = (gap_cnt > 0);
    if (gap_act) gap_cnt--;
    check_empty  = gap_act || fifo_q.size() == 0;
    data_in      = (fifo_q.size() != 0) ? {192'd0, fifo_q[0]} : '0;
    DDR_BVALID_0 = b_pend;
    DDR_RVALID_0 = r_act;
    DDR_RDATA_0  = r_act ? {192'd0, rd_tbl[r_cnt[1:0]]} : '0;
    DDR_RLAST_0  = r_act && r_cnt == 3'd3;
  end

  task automatic clear_logs();
    w_data.delete(); w_last.delete(); aw_addr.delete(); aw_type.delete();
    pops = 0; done_cnt = 0; av_cyc = 0; viol = 0; gap_en = 0; gap_done = 0;
  endtask

  task automatic load_fifo(input int n);
    fifo_q.delete();
    for (int i = 1; i <= n; i++) fifo_q.push_back(64'(((i - 1) % 4) + 1));
  endtask

  task automatic start_run(input int n, input bit v);
    @(negedge axi_clk);
    i_num_bursts = 16'(n); i_verify = v; i_start = 1;
    @(negedge axi_clk);
    i_start = 0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (o_done) seen = 1;
      else @(negedge axi_clk);
    end
    chk(tag, 64'(seen), 64'd1);
    repeat (2) @(negedge axi_clk);
  endtask

  task automatic chk_wdata(input string tag);
    chk({tag, "_nbeats"}, 64'(w_data.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_wdata%0d", tag, i), (i < w_data.size()) ? w_data[i] : 64'hDEAD, 64'(i + 1));
      chk($sformatf("%s_wlast%0d", tag, i), (i < w_last.size()) ? 64'(w_last[i]) : 64'hDEAD,
          64'(i == 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rd_tbl = '{64'd1, 64'd2, 64'd3, 64'd4};
    repeat (3) @(negedge axi_clk);
    rst = 0;
    chk("rst_busy",   64'(o_busy), 64'd0);
    chk("rst_avalid", 64'(DDR_AVALID_0), 64'd0);
    chk("rst_aaddr",  64'(DDR_AADDR_0), 64'd0);
    chk("rst_wstrb",  64'(DDR_WSTRB_0), 64'hFFFF_FFFF);
    chk("rst_alen",   64'(DDR_ALEN_0), 64'd0);
    chk("rst_wvalid", 64'(DDR_WVALID_0), 64'd0);
    chk("rst_done",   64'(o_done), 64'd0);

    // single burst, no verify
    clear_logs(); load_fifo(4);
    start_run(1, 0);
    chk("t1_busy_n1",   64'(o_busy), 64'd1);
    chk("t1_avalid_n1", 64'(DDR_AVALID_0), 64'd1);
    wait_done("t1_done");
    chk("t1_naw",   64'(aw_addr.size()), 64'd1);
    chk("t1_atype", (aw_type.size() > 0) ? 64'(aw_type[0]) : 64'hDEAD, 64'd1);
    chk("t1_aaddr", (aw_addr.size() > 0) ? aw_addr[0] : 64'hDEAD, 64'd0);
    chk("t1_alen",  64'(aw_len), 64'd3);
    chk("t1_asize", 64'(aw_size), 64'd5);
    chk_wdata("t1");
    chk("t1_pops",   64'(pops), 64'd4);
    chk("t1_bursts", 64'(o_bursts_done), 64'd1);
    chk("t1_ndone",  64'(done_cnt), 64'd1);
    chk("t1_busy",   64'(o_busy), 64'd0);

    // verify, matching readback
    clear_logs(); load_fifo(4); rd_tbl = '{64'd1, 64'd2, 64'd3, 64'd4};
    start_run(1, 1);
    wait_done("t2_done");
    chk("t2_naw",   64'(aw_addr.size()), 64'd2);
    chk("t2_rtype", (aw_type.size() > 1) ? 64'(aw_type[1]) : 64'hDEAD, 64'd0);
    chk("t2_raddr", (aw_addr.size() > 1) ? aw_addr[1] : 64'hDEAD, 64'd0);
    chk("t2_cmp",   64'(o_compare_error), 64'd0);
    chk("t2_cnt",   64'(o_err_count), 64'd0);
    chk("t2_resp",  64'(o_resp_error), 64'd0);

    // verify, one corrupted beat
    clear_logs(); load_fifo(4); rd_tbl = '{64'd1, 64'd2, 64'd9, 64'd4};
    start_run(1, 1);
    wait_done("t3_done");
    chk("t3_cmp",  64'(o_compare_error), 64'd1);
    chk("t3_cnt",  64'(o_err_count), 64'd1);
    chk("t3_resp", 64'(o_resp_error), 64'd0);

    // FIFO runs dry for 5 cycles after beat 2
    clear_logs(); load_fifo(4); gap_en = 1;
    start_run(1, 0);
    wait_done("t4_done");
    chk("t4_gap_seen", 64'(gap_done), 64'd1);
    chk("t4_gap_viol", 64'(viol), 64'd0);
    chk_wdata("t4");
    chk("t4_pops", 64'(pops), 64'd4);
    chk("t4_cmp_cleared", 64'(o_compare_error), 64'd0);

    // address window wrap at 0x100
    clear_logs(); load_fifo(12);
    start_run(3, 0);
    wait_done("t5_done");
    chk("t5_naw", 64'(aw_addr.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t5_aaddr%0d", i), (i < aw_addr.size()) ? aw_addr[i] : 64'hDEAD,
          (i == 1) ? 64'h80 : 64'h0);
    chk("t5_bursts", 64'(o_bursts_done), 64'd3);

    // reset in the middle of the write data phase
    clear_logs(); load_fifo(4);
    start_run(1, 0);
    for (int i = 0; i < 50 && w_data.size() < 2; i++) @(negedge axi_clk);
    chk("t6_reached_mid", 64'(w_data.size()), 64'd2);
    chk("t6_wvalid_pre",  64'(DDR_WVALID_0), 64'd1);
    rst = 1;
    @(negedge axi_clk);
    chk("t6_busy",   64'(o_busy), 64'd0);
    chk("t6_wvalid", 64'(DDR_WVALID_0), 64'd0);
    chk("t6_rden",   64'(read_enable), 64'd0);
    chk("t6_avalid", 64'(DDR_AVALID_0), 64'd0);
    chk("t6_wlast",  64'(DDR_WLAST_0), 64'd0);
    chk("t6_aaddr",  64'(DDR_AADDR_0), 64'd0);
    rst = 0;
    clear_logs(); load_fifo(4);
    start_run(1, 0);
    wait_done("t6_done");
    chk_wdata("t6");
    chk("t6_bursts", 64'(o_bursts_done), 64'd1);

    // zero-burst run
    clear_logs();
    start_run(0, 0);
    chk("t7_done", 64'(o_done), 64'd1);
    repeat (3) @(negedge axi_clk);
    chk("t7_avalid_cycles", 64'(av_cyc), 64'd0);
    chk("t7_bursts", 64'(o_bursts_done), 64'd0);
    chk("t7_ndone",  64'(done_cnt), 64'd1);
    chk("t7_busy",   64'(o_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_ddr_burst_master.md
# axi_ddr_burst_master

Parametrised AXI burst master that drains a first-word-fall-through FIFO into DDR through the combined-address-channel DDR port (DDR_A*/DDR_W*/DDR_B*/DDR_R*). It writes a programmable number of fixed-length INCR bursts over a wrapping address window. It can optionally read each burst back and compare it beat-for-beat against a copy held internally. It sits between the UART-side async FIFO read port and DDR controller port 0.

## Interface
- DATA_W, 256: data width in bits, power of two, 32..512
- ADDR_W, 32: address width
- ID_W, 8: transaction ID width
- AXI_ID, 0: constant ID driven on DDR_AID_0 and DDR_WID_0
- BURST_LEN, 4: beats per burst, 1..64
- START_ADDR, 32'h0: first burst address, burst-aligned
- STOP_ADDR, 32'h0010_0000: exclusive window end
---
- axi_clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  single-cycle start; ignored while o_busy
- i_num_bursts  in  16  bursts per run, sampled on i_start
- i_verify  in  1  read back and compare each burst, sampled on i_start
- i_pause  in  1  holds at the next burst boundary
- data_in  in  DATA_W  FIFO head data, valid while !check_empty
- check_empty  in  1  FIFO empty
- read_enable  out  1  FIFO pop
- DDR_AID_0/AADDR_0/ALEN_0/ASIZE_0/ABURST_0/ALOCK_0/AVALID_0/ATYPE_0  out  ID_W/ADDR_W/8/3/2/2/1/1  address channel
- DDR_AREADY_0  in  1
- DDR_WID_0/WDATA_0/WSTRB_0/WLAST_0/WVALID_0  out  ID_W/DATA_W/DATA_W/8/1/1  write data
- DDR_WREADY_0  in  1
- DDR_BID_0  in  ID_W; DDR_BVALID_0  in  1; DDR_BREADY_0  out  1
- DDR_RID_0  in  ID_W; DDR_RDATA_0  in  DATA_W; DDR_RRESP_0  in  2; DDR_RLAST_0/RVALID_0  in  1; DDR_RREADY_0  out  1
- o_busy  out  1  run in progress
- o_done  out  1  one-cycle pulse at run end
- o_bursts_done  out  16  bursts completed this run
- o_compare_error  out  1  sticky data mismatch
- o_err_count  out  16  mismatching beats, saturating
- o_resp_error  out  1  sticky: RRESP≠00, BID/RID≠AXI_ID, or RLAST misplaced

## Operation
- Fixed address-channel fields: ALEN=BURST_LEN-1, ASIZE=log2(DATA_W/8), ABURST=01, ALOCK=00, AID=AXI_ID, WSTRB all ones.
- States:
  - IDLE: on i_start with i_num_bursts≠0, go to WR_ADDR. On i_start with i_num_bursts=0, pulse o_done the next cycle and issue no transaction.
  - WR_ADDR: AVALID=1, ATYPE=1. On AREADY, go to WR_DATA.
  - WR_DATA: WVALID=!check_empty; WDATA=data_in; read_enable=WVALID&WREADY. Each accepted beat is stored in buffer[beat] when i_verify is set. WLAST=1 on beat BURST_LEN-1. Acceptance of the last beat goes to WR_RESP.
  - WR_RESP: BREADY=1. On BVALID, go to RD_ADDR if verify, else NEXT.
  - RD_ADDR: AVALID=1, ATYPE=0, same address as the write. On AREADY, go to RD_DATA.
  - RD_DATA: RREADY=1. Each RVALID beat is compared with buffer[beat]. A mismatch sets o_compare_error and increments o_err_count. The beat with beat=BURST_LEN-1 goes to NEXT.
  - NEXT: increment o_bursts_done. Next address = addr + BURST_LEN·DATA_W/8; if that is ≥ STOP_ADDR, wrap to START_ADDR. Go to IDLE with a done pulse if the count is reached. Otherwise hold while i_pause, then go to WR_ADDR.
- Write data is never held in a register: an empty FIFO mid-burst drops WVALID. WVALID cannot fall without a handshake, because FWFT data persists until it is popped.
- Address fields are registered and stable while AVALID=1. AVALID is never deasserted before AREADY.
- RLAST on a beat other than BURST_LEN-1, or missing on that beat, sets o_resp_error. The beat count still ends the burst.
- o_compare_error, o_err_count, o_resp_error and o_bursts_done clear on i_start.

## Timing
- Reset: every output is 0 except DDR_WSTRB_0 = all ones and DDR_AADDR_0 = START_ADDR. State returns to IDLE. Any in-flight transaction is abandoned; the DDR controller must be reset alongside.
- i_start at cycle N: o_busy=1 and AVALID=1 at N+1.
- A handshake at cycle N: the next channel's valid/ready is asserted at N+1.
- Minimum write burst: 1 (address) + BURST_LEN (data) + 1 (response) cycles, zero-wait.
- o_done: one cycle after the last NEXT; o_busy falls in the same cycle.
- i_pause is sampled only in NEXT. Mid-burst i_pause has no effect.

## Test plan
- DATA_W=256, BURST_LEN=4, 1 burst, no verify, FIFO holds 1..4 -> one address beat (ATYPE=1, ALEN=3, AADDR=0, ASIZE=5); WDATA 1,2,3,4 with WLAST on 4; 4 pops; BREADY until BVALID; o_done; o_bursts_done=1.
- Same with verify, slave returns 1..4 -> read address AADDR=0, ATYPE=0; o_compare_error=0, o_err_count=0.
- Verify, slave returns 1,2,9,4 -> o_compare_error=1, o_err_count=1.
- FIFO empty for 5 cycles after beat 2 -> WVALID=0 and read_enable=0 during the gap; burst completes with 4 beats.
- STOP_ADDR=0x100, 3 bursts -> AADDR 0x0, 0x80, 0x0.
- rst asserted mid-WR_DATA -> all outputs at reset values next cycle; a new i_start runs cleanly. Also: i_num_bursts=0 -> o_done with no AVALID.
